aes_out_serializer: RTL and testbench

//  Output stage after the AES round/control pipeline. Captures each 130-bit result (valid, type, 128-bit block),

---
 rtl/aes_out_serializer.sv | 110 +++++++++++
 tb/tb_aes_out_serializer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_out_serializer.sv
// aes_out_serializer: output stage after the AES round pipeline.
// Each 130-bit result {valid, type, block} arrives as a one-cycle strobe with
// no backpressure. The block is buffered in a DEPTH-entry FIFO and sent as four
// 32-bit words, most significant word first, on a valid/ready port.
// Blocks that arrive while the FIFO is full are dropped, and a sticky overflow
// flag records the drop.
// Optional feature: define AES_OUT_DROP_CNT_EN to add a saturating 16-bit
// count of dropped blocks on the drop_cnt output.
//
// Handshake: a word moves when o_valid && o_ready at the rising clock edge.
// While o_valid is high and o_ready is low, o_data, o_type and o_last stay
// unchanged. o_valid does not depend on o_ready.
module aes_out_serializer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vin,
  input  logic          tin,
  input  logic [127:0]  din,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [31:0]   o_data,
  output logic          o_type,
  output logic          o_last,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow
`ifdef AES_OUT_DROP_CNT_EN
  ,
  output logic [15:0]   drop_cnt
`endif
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  // Each entry holds {type, data}.
  logic [128:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    idx;
  logic [128:0]  head;
  logic          xfer;
  logic          pop;
  logic          push;
  logic          drop;

  // Decode the handshake, the pop of the last word, and whether to accept or drop the input block.
  always_comb begin
    xfer = o_valid & o_ready;
    pop  = xfer & (idx == 2'd3);
    // The slot freed by a pop in this cycle can take the arriving block.
    push = vin & ((count != FULL_CNT) | pop);
    drop = vin & ~push;
  end

  // Select the current word of the head entry. The outputs are forced to zero when the FIFO is empty.
  always_comb begin
    head    = mem[rd_ptr];
    o_valid = (count != '0);
    full    = (count == FULL_CNT);
    o_data  = '0;
    o_type  = 1'b0;
    o_last  = 1'b0;
    if (o_valid) begin
      o_type = head[128];
      o_last = (idx == 2'd3);
      case (idx)
        2'd0:    o_data = head[127:96];
        2'd1:    o_data = head[95:64];
        2'd2:    o_data = head[63:32];
        default: o_data = head[31:0];
      endcase
    end
  end

  // Storage array write. It needs no reset because the pointers and the count decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {tin, din};
  end

  // Pointers, word index, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      idx      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      // The 2-bit index wraps from 3 back to 0 on the last word.
      if (xfer) idx <= idx + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef AES_OUT_DROP_CNT_EN
  // Saturating count of dropped blocks. Only reset clears it.
  always_ff @(posedge clk) begin
    if (rst)                             drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_aes_out_serializer.sv
// tb_aes_out_serializer: directed vectors for aes_out_serializer.
// A table covers single-block and back-to-back serialization. Hand-written
// sequences cover overflow, push during pop, stalls and mid-transfer reset.
module tb_aes_out_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic         vin;
  logic         tin;
  logic [127:0] din;
  logic         o_valid;
  logic         o_ready;
  logic [31:0]  o_data;
  logic         o_type;
  logic         o_last;
  logic         full;
  logic [2:0]   count;
  logic         overflow;
`ifdef AES_OUT_DROP_CNT_EN
  logic [15:0]  drop_cnt;
`endif

  int n_total = 0;
  int n_pass  = 0;

  aes_out_serializer #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst(rst), .vin(vin), .tin(tin), .din(din),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_type(o_type),
    .o_last(o_last), .full(full), .count(count), .overflow(overflow)
`ifdef AES_OUT_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  // Clock generation
  always #5 clk = ~clk;

  typedef struct {
    logic         vin;
    logic         tin;
    logic [127:0] din;
    logic         rdy;
    logic         e_valid;
    logic [31:0]  e_data;
    logic         e_type;
    logic         e_last;
    logic [2:0]   e_count;
    logic         e_full;
    logic         e_ovf;
  } vec_t;

  vec_t tbl[15];

  localparam logic [127:0] B1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] B2 = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
  localparam logic [127:0] B3 = 128'h11111111_22222222_33333333_44444444;

  function automatic vec_t mk(input logic v, input logic t, input logic [127:0] d, input logic r,
                              input logic ev, input logic [31:0] ed, input logic et, input logic el,
                              input logic [2:0] ec, input logic ef, input logic eo);
    vec_t x;
    x.vin = v; x.tin = t; x.din = d; x.rdy = r;
    x.e_valid = ev; x.e_data = ed; x.e_type = et; x.e_last = el;
    x.e_count = ec; x.e_full = ef; x.e_ovf = eo;
    return x;
  endfunction

  function automatic logic [31:0] word(input int k, input int j);
    return {8'(k), 8'(j), 16'hBEEF};
  endfunction

  function automatic logic [127:0] blk(input int k);
    return {word(k, 0), word(k, 1), word(k, 2), word(k, 3)};
  endfunction

  // Scoreboard compare
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; vin = 1'b0; tin = 1'b0; din = '0; o_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_blk(input int k, input logic t);
    @(negedge clk);
    vin = 1'b1; tin = t; din = blk(k);
  endtask

  // Check that block k (type t) drains fully with o_ready held high
  task automatic drain_blk(input int k, input logic t);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("drain%0d.valid", k), o_valid, 1'b1);
      chk($sformatf("drain%0d.w%0d", k, j), o_data, word(k, j));
      chk($sformatf("drain%0d.type", k), o_type, t);
      chk($sformatf("drain%0d.last%0d", k, j), o_last, (j == 3));
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    logic [8:0] pat;
    int ej;

    rst = 1'b1; vin = 1'b0; tin = 1'b0; din = '0; o_ready = 1'b0;

    // Single block, then two back-to-back blocks of opposite type
    tbl[0]  = mk(1, 0, B1, 1, 0, 32'h0,        0, 0, 3'd0, 0, 0);
    tbl[1]  = mk(0, 0, '0, 1, 1, 32'h00112233, 0, 0, 3'd1, 0, 0);
    tbl[2]  = mk(0, 0, '0, 1, 1, 32'h44556677, 0, 0, 3'd1, 0, 0);
    tbl[3]  = mk(0, 0, '0, 1, 1, 32'h8899AABB, 0, 0, 3'd1, 0, 0);
    tbl[4]  = mk(0, 0, '0, 1, 1, 32'hCCDDEEFF, 0, 1, 3'd1, 0, 0);
    tbl[5]  = mk(1, 1, B2, 1, 0, 32'h0,        0, 0, 3'd0, 0, 0);
    tbl[6]  = mk(1, 0, B3, 1, 1, 32'hA0A1A2A3, 1, 0, 3'd1, 0, 0);
    tbl[7]  = mk(0, 0, '0, 1, 1, 32'hB0B1B2B3, 1, 0, 3'd2, 0, 0);
    tbl[8]  = mk(0, 0, '0, 1, 1, 32'hC0C1C2C3, 1, 0, 3'd2, 0, 0);
    tbl[9]  = mk(0, 0, '0, 1, 1, 32'hD0D1D2D3, 1, 1, 3'd2, 0, 0);
    tbl[10] = mk(0, 0, '0, 1, 1, 32'h11111111, 0, 0, 3'd1, 0, 0);
    tbl[11] = mk(0, 0, '0, 1, 1, 32'h22222222, 0, 0, 3'd1, 0, 0);
    tbl[12] = mk(0, 0, '0, 1, 1, 32'h33333333, 0, 0, 3'd1, 0, 0);
    tbl[13] = mk(0, 0, '0, 1, 1, 32'h44444444, 0, 1, 3'd1, 0, 0);
    tbl[14] = mk(0, 0, '0, 1, 0, 32'h0,        0, 0, 3'd0, 0, 0);

    reset_dut();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      vin = tbl[i].vin; tin = tbl[i].tin; din = tbl[i].din; o_ready = tbl[i].rdy;
      #1;
      chk($sformatf("t%0d.valid", i), o_valid,  tbl[i].e_valid);
      chk($sformatf("t%0d.data", i),  o_data,   tbl[i].e_data);
      chk($sformatf("t%0d.type", i),  o_type,   tbl[i].e_type);
      chk($sformatf("t%0d.last", i),  o_last,   tbl[i].e_last);
      chk($sformatf("t%0d.count", i), count,    tbl[i].e_count);
      chk($sformatf("t%0d.full", i),  full,     tbl[i].e_full);
      chk($sformatf("t%0d.ovf", i),   overflow, tbl[i].e_ovf);
    end

    // Overflow: four blocks fill the FIFO and the fifth is dropped
    reset_dut();
    o_ready = 1'b0;
    for (int k = 1; k <= 5; k++) push_blk(k, 1'b0);
    #1;
    chk("ovf.count4", count, 3'd4);
    chk("ovf.full", full, 1'b1);
    chk("ovf.pre", overflow, 1'b0);
    @(negedge clk);
    vin = 1'b0;
    #1;
    chk("ovf.count_after", count, 3'd4);
    chk("ovf.flag", overflow, 1'b1);
    chk("ovf.stall_data", o_data, word(1, 0));
`ifdef AES_OUT_DROP_CNT_EN
    chk("ovf.drop_cnt", drop_cnt, 16'd1);
`endif
    o_ready = 1'b1;
    for (int k = 1; k <= 4; k++) drain_blk(k, 1'b0);
    chk("ovf.empty_valid", o_valid, 1'b0);
    chk("ovf.empty_count", count, 3'd0);
    chk("ovf.sticky", overflow, 1'b1);

    // Reset after part of a block has been sent, with two blocks stored
    o_ready = 1'b0;
    push_blk(8, 1'b0);
    push_blk(9, 1'b0);
    @(negedge clk);
    vin = 1'b0; o_ready = 1'b1;
    #1;
    chk("mrst.w0", o_data, word(8, 0));
    @(negedge clk);
    #1;
    chk("mrst.w1", o_data, word(8, 1));
    @(negedge clk);
    #1;
    chk("mrst.w2", o_data, word(8, 2));
    chk("mrst.count2", count, 3'd2);
    rst = 1'b1; o_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst.valid", o_valid, 1'b0);
    chk("mrst.count", count, 3'd0);
    chk("mrst.ovf", overflow, 1'b0);
    chk("mrst.data", o_data, 32'h0);
    chk("mrst.full", full, 1'b0);
`ifdef AES_OUT_DROP_CNT_EN
    chk("mrst.drop_cnt", drop_cnt, 16'd0);
`endif
    vin = 1'b1; tin = 1'b1; din = blk(10); o_ready = 1'b1;
    @(negedge clk);
    vin = 1'b0;
    #1;
    drain_blk(10, 1'b1);
    chk("mrst.end_valid", o_valid, 1'b0);

    // Push into a full FIFO in the same cycle as the last-word pop
    reset_dut();
    o_ready = 1'b0;
    for (int k = 1; k <= 4; k++) push_blk(k, 1'b0);
    @(negedge clk);
    vin = 1'b0; o_ready = 1'b1;
    #1;
    chk("pp.full", full, 1'b1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pp.last", o_last, 1'b1);
    vin = 1'b1; tin = 1'b0; din = blk(6);
    @(negedge clk);
    vin = 1'b0; o_ready = 1'b0;
    #1;
    chk("pp.count", count, 3'd4);
    chk("pp.full_after", full, 1'b1);
    chk("pp.ovf", overflow, 1'b0);
    chk("pp.head", o_data, word(2, 0));
    o_ready = 1'b1;
    drain_blk(2, 1'b0);
    drain_blk(3, 1'b0);
    drain_blk(4, 1'b0);
    drain_blk(6, 1'b0);
    chk("pp.empty", o_valid, 1'b0);

    // Stalls in the middle of a block
    reset_dut();
    push_blk(7, 1'b1);
    @(negedge clk);
    vin = 1'b0;
    pat = 9'b100101001;
    ej = 0;
    for (int c = 0; c < 9; c++) begin
      #1;
      chk($sformatf("stall%0d.valid", c), o_valid, 1'b1);
      chk($sformatf("stall%0d.data", c), o_data, word(7, ej));
      chk($sformatf("stall%0d.type", c), o_type, 1'b1);
      chk($sformatf("stall%0d.last", c), o_last, (ej == 3));
      o_ready = pat[c];
      @(negedge clk);
      if (o_ready) ej++;
    end
    #1;
    chk("stall.done", o_valid, 1'b0);
    chk("stall.count", count, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
